platform_scheduler: RTL
=======================

Name: platform_scheduler

Overview:
- Owns the table of platform positions drawn by the colour mapper.
- Once per frame it scrolls all platforms down when the doodle climbs above a scroll line.
- Platforms that fall off the bottom respawn at the top at a pseudo-random X.
- Exposes a registered read port the colour mapper pipeline indexes per platform, plus the scroll amount and a running score.

Parameters:
- N_PLAT, 8, number of platform table entries (power of 2, index width log2(N_PLAT))
- SCREEN_H, 480, visible lines; wrap threshold for Y
- SCROLL_LINE, 200, doodle Y above which scrolling occurs
- MAX_SCROLL, 31, clamp on per-frame scroll in pixels
- X_SPAN, 560, legal platform X range [0, X_SPAN-1] (640 minus 80-pixel platform width)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- doodle_y  in  10  doodle top Y, sampled on frame_start
- rd_idx  in  3  platform index to read
- rd_x  out  10  X of entry rd_idx, registered
- rd_y  out  10  Y of entry rd_idx, registered
- scroll_amt  out  5  scroll applied this frame; holds until next CALC
- update_busy  out  1  high while the table is being updated
- update_done  out  1  one-cycle pulse when the update completes
- score  out  16  saturating sum of all scroll_amt values

Behaviour:
- Reset is asynchronous, active-low, and overrides everything including a walk in progress:
  - entry i gets x = 40 + 70*i, y = 60*i
  - LFSR = 16'hACE1
  - FSM = IDLE
  - rd_x, rd_y, scroll_amt, score, update_busy, update_done = 0
- FSM IDLE: on frame_start go to CALC and latch doodle_y. frame_start in any other state is ignored; no queuing.
- CALC, one cycle:
  - scroll = (doodle_y < SCROLL_LINE) ? min(SCROLL_LINE - doodle_y, MAX_SCROLL) : 0; register it into scroll_amt.
  - score <= score + scroll, saturating at 16'hFFFF.
  - Entry counter cleared. Go to WALK.
- WALK, one entry per cycle for N_PLAT cycles, index 0 first:
  - y_new = y + scroll_amt, computed in 11 bits.
  - If y_new >= SCREEN_H: y <= y_new - SCREEN_H and x <= respawn_x.
  - Otherwise y <= y_new and x is unchanged.
  - After the last index, go to DONE.
- respawn_x: r = LFSR[9:0]; x = (r >= X_SPAN) ? r - X_SPAN : r. A single subtract suffices because 1023 - 560 < 560.
- LFSR:
  - Fibonacci, taps 16, 14, 13, 11.
  - Shift left, feedback = b15^b13^b12^b10 into bit 0.
  - Advances every clock in every state except reset.
- DONE: update_done = 1 for exactly this cycle, then IDLE.
- Timing: update_busy = 1 in CALC, WALK and DONE. With frame_start at cycle 0:
  - CALC at cycle 1
  - WALK at cycles 2 .. N_PLAT+1
  - DONE at cycle N_PLAT+2
- Read port:
  - rd_x/rd_y <= table[rd_idx] every cycle; 1-cycle latency.
  - Reads during WALK return the current, possibly partly updated, contents.
  - If rd_idx names the entry being written in the same cycle, the read returns the old value (read-before-write).
- scroll_amt = 0 still runs a full WALK with no Y change and no respawn.
- Y never exceeds SCREEN_H-1 after an update, because every entry starts below SCREEN_H and MAX_SCROLL < SCREEN_H.

Test Plan:
- Reset then rd_idx=3 -> next cycle rd_x=250, rd_y=180; rd_idx=7 -> rd_x=530, rd_y=420; score=0, update_busy=0.
- frame_start with doodle_y=300 -> scroll_amt=0, update_busy high for 10 cycles (cycles 1-10), update_done pulse at cycle 10, all entries unchanged, score=0.
- frame_start with doodle_y=190 -> scroll_amt=10, entry 3 reads y=190 after done, score=10; a second frame with doodle_y=100 -> scroll_amt=31 (clamped), score=41.
- Wrap: from reset, two frames with doodle_y=0 (scroll 31 each) -> entry 7 y=451 then 482 wraps to y=2; its x equals the reference-model respawn_x, lies in 0..559, and differs from 530.
- frame_start pulsed again at cycle 4 of a walk -> ignored: exactly one update_done, score incremented once.
- Reset_n asserted at cycle 5 of a walk -> outputs and table immediately return to reset values; a subsequent frame with doodle_y=190 produces entry 0 y=10.

Source files
------------

// File: rtl/platform_scheduler_if.sv
// Bus between the platform scheduler and the colour mapper: frame trigger,
// doodle height, indexed table read port and per-frame status.
interface platform_scheduler_if #(
  parameter int N_PLAT = 8
);
  localparam int IDX_W = $clog2(N_PLAT);

  logic             frame_start;
  logic [9:0]       doodle_y;
  logic [IDX_W-1:0] rd_idx;
  logic [9:0]       rd_x;
  logic [9:0]       rd_y;
  logic [4:0]       scroll_amt;
  logic             update_busy;
  logic             update_done;
  logic [15:0]      score;

  // Requester side (colour mapper / frame timing)
  modport master (
    output frame_start, doodle_y, rd_idx,
    input  rd_x, rd_y, scroll_amt, update_busy, update_done, score
  );

  // Scheduler side
  modport slave (
    input  frame_start, doodle_y, rd_idx,
    output rd_x, rd_y, scroll_amt, update_busy, update_done, score
  );
endinterface

// File: rtl/platform_scheduler.sv
// Platform table owner: once per frame scrolls every platform down by the
// amount the doodle has climbed past the scroll line, respawns platforms that
// drop off the bottom at a pseudo-random X, and serves a registered read port.
module platform_scheduler #(
  parameter int N_PLAT      = 8,
  parameter int SCREEN_H    = 480,
  parameter int SCROLL_LINE = 200,
  parameter int MAX_SCROLL  = 31,
  parameter int X_SPAN      = 560
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  platform_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(N_PLAT);

  typedef enum logic [1:0] {IDLE, CALC, WALK, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [9:0]       doodle_q, doodle_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       x_q [N_PLAT];
  logic [9:0]       x_d [N_PLAT];
  logic [9:0]       y_q [N_PLAT];
  logic [9:0]       y_d [N_PLAT];
  logic [9:0]       rd_x_q, rd_x_d;
  logic [9:0]       rd_y_q, rd_y_d;
  logic [4:0]       scroll_q, scroll_d;
  logic [15:0]      score_q, score_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [10:0]      y_new;

  // Scroll distance for a doodle height, clamped to the per-frame maximum.
  function automatic logic [4:0] calc_scroll(input logic [9:0] dy);
    logic [9:0] diff;
    diff        = 10'(SCROLL_LINE) - dy;
    calc_scroll = '0;
    if (dy < 10'(SCROLL_LINE)) begin
      if (diff > 10'(MAX_SCROLL)) calc_scroll = 5'(MAX_SCROLL);
      else                        calc_scroll = 5'(diff);
    end
  endfunction

  // Score accumulation that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'b0, b};
    sat_add16 = s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Fold a 10-bit random value into [0, X_SPAN-1]; one subtract is enough
  // because the excess range above X_SPAN is smaller than X_SPAN.
  function automatic logic [9:0] respawn_x(input logic [9:0] r);
    respawn_x = (r >= 10'(X_SPAN)) ? (r - 10'(X_SPAN)) : r;
  endfunction

  // Next-state logic: FSM sequencing, table walk, LFSR and read port.
  always_comb begin
    state_d  = state_q;
    doodle_d = doodle_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    scroll_d = scroll_q;
    score_d  = score_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Read from the current table so a same-cycle write returns the old value.
    rd_x_d   = x_q[bus.rd_idx];
    rd_y_d   = y_q[bus.rd_idx];
    y_new    = {1'b0, y_q[idx_q]} + {6'b0, scroll_q};

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d  = CALC;
          doodle_d = bus.doodle_y;
        end
      end
      CALC: begin
        scroll_d = calc_scroll(doodle_q);
        score_d  = sat_add16(score_q, calc_scroll(doodle_q));
        idx_d    = '0;
        state_d  = WALK;
      end
      WALK: begin
        if (y_new >= 11'(SCREEN_H)) begin
          y_d[idx_q] = 10'(y_new - 11'(SCREEN_H));
          x_d[idx_q] = respawn_x(lfsr_q[9:0]);
        end else begin
          y_d[idx_q] = y_new[9:0];
        end
        if (idx_q == IDX_W'(N_PLAT - 1)) state_d = DONE;
        else                             idx_d   = idx_q + IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, table and output registers; reset restores the initial layout.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      lfsr_q   <= 16'hACE1;
      doodle_q <= '0;
      idx_q    <= '0;
      for (int i = 0; i < N_PLAT; i++) begin
        x_q[i] <= 10'(40 + 70 * i);
        y_q[i] <= 10'(60 * i);
      end
      rd_x_q   <= '0;
      rd_y_q   <= '0;
      scroll_q <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      doodle_q <= doodle_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rd_x_q   <= rd_x_d;
      rd_y_q   <= rd_y_d;
      scroll_q <= scroll_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rd_x        = rd_x_q;
  assign bus.rd_y        = rd_y_q;
  assign bus.scroll_amt  = scroll_q;
  assign bus.score       = score_q;
  assign bus.update_busy = busy_q;
  assign bus.update_done = done_q;

endmodule
